// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: selects ALU operands A/B, forwards RAW hazards, one-entry output slot.
// Latency: one cycle (accept on edge N, operands valid after edge N); full throughput.
// Backpressure: in_ready drops on load-use hazard, flush, or full slot with out_ready low.
module alu_operand_stage #(
    parameter int XLEN        = 32,
    parameter int NUM_FWD     = 2,
    parameter int RAW         = 5,
    parameter int STALL_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              src_a_sel,
    input  logic [1:0]              src_b_sel,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    input  logic [RAW-1:0]          rs1_addr,
    input  logic [RAW-1:0]          rs2_addr,
    input  logic [XLEN-1:0]         rs1_data,
    input  logic [XLEN-1:0]         rs2_data,
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         imm,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*RAW-1:0]  fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         op_a,
    output logic [XLEN-1:0]         op_b,
    output logic [XLEN-1:0]         rs2_val,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);

    localparam logic [XLEN-1:0] CONST4 = XLEN'(4);

    typedef struct packed {
        logic            pend;
        logic [XLEN-1:0] val;
    } src_res_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    src_res_t        rs1_res;
    src_res_t        rs2_res;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] op_a_nxt;
    logic [XLEN-1:0] op_b_nxt;

    // Scan oldest to youngest so the youngest matching entry overrides.
    function automatic src_res_t resolve(
        input logic [RAW-1:0]          addr,
        input logic [XLEN-1:0]         rf_data,
        input logic [NUM_FWD-1:0]      fv,
        input logic [NUM_FWD-1:0]      fp,
        input logic [NUM_FWD*RAW-1:0]  fa,
        input logic [NUM_FWD*XLEN-1:0] fd
    );
        src_res_t r;
        r.val  = rf_data;
        r.pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fv[i] && (fa[i*RAW +: RAW] == addr)) begin
                r.val  = fd[i*XLEN +: XLEN];
                r.pend = fp[i];
            end
        end
        if (addr == '0) begin
            r.val  = '0;
            r.pend = 1'b0;
        end
        return r;
    endfunction

    always_comb begin
        rs1_res = resolve(rs1_addr, rs1_data, fwd_valid, fwd_pending, fwd_addr, fwd_data);
        rs2_res = resolve(rs2_addr, rs2_data, fwd_valid, fwd_pending, fwd_addr, fwd_data);
    end

    assign hazard   = (rs1_used && rs1_res.pend) || (rs2_used && rs2_res.pend);
    assign in_ready = !flush && !hazard && ((state == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_valid = (state == FULL);

    always_comb begin
        op_a_nxt = '0;
        case (src_a_sel)
            2'd0:    op_a_nxt = rs1_res.val;
            2'd1:    op_a_nxt = pc;
            default: op_a_nxt = '0;
        endcase
    end

    always_comb begin
        op_b_nxt = '0;
        case (src_b_sel)
            2'd0:    op_b_nxt = rs2_res.val;
            2'd1:    op_b_nxt = imm;
            2'd2:    op_b_nxt = CONST4;
            default: op_b_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            op_a    <= '0;
            op_b    <= '0;
            rs2_val <= '0;
        end else begin
            // Flush wins over both accept and drain.
            if (flush) begin
                state <= EMPTY;
            end else if (accept) begin
                state   <= FULL;
                op_a    <= op_a_nxt;
                op_b    <= op_b_nxt;
                rs2_val <= rs2_res.val;
            end else if ((state == FULL) && out_ready) begin
                state <= EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && !flush && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed vector table, hand sequences, randomized run vs reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, flush, out_ready;
    logic [1:0]  src_a_sel, src_b_sel;
    logic        rs1_used, rs2_used;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data, pc, imm;
    logic [1:0]  fv, fp;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;

    logic        in_ready, out_valid;
    logic [31:0] op_a, op_b, rs2_val;
    logic [7:0]  stall_cnt;
    logic        d2_in_ready, d2_out_valid;
    logic [31:0] d2_op_a, d2_op_b, d2_rs2_val;
    logic [1:0]  d2_stall_cnt;

    assign fwd_addr = {fa1, fa0};
    assign fwd_data = {fd1, fd0};

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm), .fwd_valid(fv), .fwd_pending(fp), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .rs2_val(rs2_val), .stall_cnt(stall_cnt)
    );

    alu_operand_stage #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
        .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .pc(pc), .imm(imm), .fwd_valid(fv), .fwd_pending(fp), .fwd_addr(fwd_addr),
        .fwd_data(fwd_data), .flush(flush), .out_valid(d2_out_valid), .out_ready(out_ready),
        .op_a(d2_op_a), .op_b(d2_op_b), .rs2_val(d2_rs2_val), .stall_cnt(d2_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  a_sel, b_sel;
        logic [4:0]  rs1, rs2;
        logic [31:0] r1d, r2d, pcv, immv;
        logic [1:0]  fvv, fpv;
        logic [4:0]  fa0v, fa1v;
        logic [31:0] fd0v, fd1v;
        logic [31:0] ea, eb, er2;
    } vec_t;

    vec_t vecs[8];

    // Reference model: slot contents and stall counters in plain variables.
    bit          m_full;
    logic [31:0] m_a, m_b, m_r2;
    int          m_cnt, m_cnt2;

    task automatic model_resolve(input logic [4:0] addr, input logic [31:0] rdata,
                                 output logic [31:0] val, output bit pend);
        val  = rdata;
        pend = 1'b0;
        if (addr == 5'd0) val = 32'd0;
        else if (fv[0] && fa0 == addr) begin val = fd0; pend = fp[0]; end
        else if (fv[1] && fa1 == addr) begin val = fd1; pend = fp[1]; end
    endtask

    task automatic rand_cycle();
        logic [31:0] v1, v2, ea, eb;
        bit p1, p2, hz, rdy;
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 15) == 0);
        src_a_sel = 2'($urandom_range(0, 3));
        src_b_sel = 2'($urandom_range(0, 3));
        rs1_used  = 1'($urandom);
        rs2_used  = 1'($urandom);
        rs1_addr  = 5'($urandom_range(0, 3));
        rs2_addr  = 5'($urandom_range(0, 3));
        rs1_data  = $urandom;  rs2_data = $urandom;
        pc        = $urandom;  imm      = $urandom;
        fv        = 2'($urandom);
        fp        = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        fa0       = 5'($urandom_range(0, 3));
        fa1       = 5'($urandom_range(0, 3));
        fd0       = $urandom;  fd1      = $urandom;
        #1;
        model_resolve(rs1_addr, rs1_data, v1, p1);
        model_resolve(rs2_addr, rs2_data, v2, p2);
        hz  = (rs1_used && p1) || (rs2_used && p2);
        rdy = !flush && !hz && (!m_full || out_ready);
        chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
        ea = (src_a_sel == 2'd0) ? v1 : (src_a_sel == 2'd1) ? pc : 32'd0;
        eb = (src_b_sel == 2'd0) ? v2 : (src_b_sel == 2'd1) ? imm :
             (src_b_sel == 2'd2) ? 32'd4 : 32'd0;
        @(posedge clk);
        if (flush) m_full = 1'b0;
        else if (in_valid && rdy) begin m_full = 1'b1; m_a = ea; m_b = eb; m_r2 = v2; end
        else if (m_full && out_ready) m_full = 1'b0;
        if (in_valid && hz && !flush) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        #1;
        chk("rnd_out_valid", 32'(out_valid), 32'(m_full));
        if (m_full) begin
            chk("rnd_op_a", op_a, m_a);
            chk("rnd_op_b", op_b, m_b);
            chk("rnd_rs2_val", rs2_val, m_r2);
        end
        chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("rnd_stall_cnt_w2", 32'(d2_stall_cnt), 32'(m_cnt2));
    endtask

    initial begin
        vecs[0] = '{1, 1, 0, 0, 'h11, 'h22, 'h100, 'hFFFFFFF0, 0, 0, 0, 0, 0, 0, 'h100, 'hFFFFFFF0, 0};
        vecs[1] = '{0, 2, 5, 6, 'h1, 'h66, 0, 0, 3, 0, 5, 5, 'hAA, 'hBB, 'hAA, 4, 'h66};
        vecs[2] = '{0, 3, 0, 0, 'h1234, 'h99, 0, 0, 3, 0, 0, 0, 'h55, 'h56, 0, 0, 0};
        vecs[3] = '{2, 0, 9, 9, 'h5, 'hDEAD, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 'hDEAD, 'hDEAD};
        vecs[4] = '{3, 0, 1, 7, 'h8, 'h1, 'h20, 0, 2, 0, 7, 7, 'hEE, 'h77, 0, 'h77, 'h77};
        vecs[5] = '{0, 1, 3, 2, 'h30, 'h20, 0, 'h1234, 3, 2, 3, 3, 'h33, 'h44, 'h33, 'h1234, 'h20};
        vecs[6] = '{0, 0, 4, 4, 'h40, 'h41, 0, 0, 1, 0, 4, 0, 'h400, 0, 'h400, 'h400, 'h400};
        vecs[7] = '{1, 2, 0, 0, 0, 0, 'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 'hFFFFFFFC, 4, 0};

        rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 0;
        src_a_sel = 0; src_b_sel = 0; rs1_used = 0; rs2_used = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_data = 0; rs2_data = 0; pc = 0; imm = 0;
        fv = 0; fp = 0; fa0 = 0; fa1 = 0; fd0 = 0; fd1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_rs2_val", rs2_val, 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Directed vector table, back-to-back with out_ready high.
        for (int k = 0; k < 8; k++) begin
            src_a_sel = vecs[k].a_sel; src_b_sel = vecs[k].b_sel;
            rs1_used = 1; rs2_used = 1;
            rs1_addr = vecs[k].rs1; rs2_addr = vecs[k].rs2;
            rs1_data = vecs[k].r1d; rs2_data = vecs[k].r2d;
            pc = vecs[k].pcv; imm = vecs[k].immv;
            fv = vecs[k].fvv; fp = vecs[k].fpv;
            fa0 = vecs[k].fa0v; fa1 = vecs[k].fa1v;
            fd0 = vecs[k].fd0v; fd1 = vecs[k].fd1v;
            in_valid = 1; out_ready = 1;
            #1;
            chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 1);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 1);
            chk($sformatf("vec%0d_op_a", k), op_a, vecs[k].ea);
            chk($sformatf("vec%0d_op_b", k), op_b, vecs[k].eb);
            chk($sformatf("vec%0d_rs2_val", k), rs2_val, vecs[k].er2);
        end

        // Load-use on rs2 via pending fwd1 for three cycles.
        src_a_sel = 1; pc = 'h111; src_b_sel = 0;
        rs1_used = 0; rs2_used = 1; rs2_addr = 7; rs2_data = 'h1;
        fv = 2'b10; fp = 2'b10; fa0 = 0; fa1 = 7; fd0 = 0; fd1 = 'h700;
        chk("lu_cnt_before", 32'(stall_cnt), 0);
        repeat (3) begin
            #1;
            chk("lu_in_ready_stalled", 32'(in_ready), 0);
            @(posedge clk);
        end
        #1;
        chk("lu_stall_cnt", 32'(stall_cnt), 3);
        chk("lu_stall_cnt_w2", 32'(d2_stall_cnt), 3);
        chk("lu_drained", 32'(out_valid), 0);
        fp = 2'b00; fd1 = 'h701;
        #1;
        chk("lu_in_ready_release", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("lu_out_valid", 32'(out_valid), 1);
        chk("lu_rs2_val", rs2_val, 'h701);
        chk("lu_op_b", op_b, 'h701);
        chk("lu_op_a", op_a, 'h111);
        chk("lu_stall_cnt_after", 32'(stall_cnt), 3);

        // Backpressure while FULL, then back-to-back transfers.
        out_ready = 0; pc = 'h200; fv = 0;
        repeat (4) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_op_a_stable", op_a, 'h111);
            chk("bp_rs2_stable", rs2_val, 'h701);
        end
        out_ready = 1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        chk("b2b_first_valid", 32'(out_valid), 1);
        chk("b2b_first_op_a", op_a, 'h200);
        pc = 'h300;
        @(posedge clk);
        #1;
        chk("b2b_second_valid", 32'(out_valid), 1);
        chk("b2b_second_op_a", op_a, 'h300);
        chk("b2b_op_b", op_b, 'h1);

        // Flush while FULL with a new instruction presented.
        out_ready = 0; pc = 'h400; flush = 1; in_valid = 1;
        #1;
        chk("fl_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        chk("fl_out_valid", 32'(out_valid), 0);
        flush = 0; in_valid = 0;
        @(posedge clk);
        #1;
        chk("fl_not_captured", 32'(out_valid), 0);

        // Fill slot, stall five cycles (saturation on the narrow counter), reset mid-stall.
        pc = 'h500; in_valid = 1; out_ready = 0; rs1_used = 0; rs2_used = 0;
        @(posedge clk);
        #1;
        chk("sat_fill_valid", 32'(out_valid), 1);
        chk("sat_fill_op_a", op_a, 'h500);
        rs1_used = 1; rs1_addr = 4; fv = 2'b01; fp = 2'b01; fa0 = 4;
        repeat (5) @(posedge clk);
        #1;
        chk("sat_stall_cnt_w8", 32'(stall_cnt), 8);
        chk("sat_stall_cnt_w2", 32'(d2_stall_cnt), 3);
        chk("sat_hold_valid", 32'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(out_valid), 0);
        chk("mrst_op_a", op_a, 0);
        chk("mrst_op_b", op_b, 0);
        chk("mrst_rs2_val", rs2_val, 0);
        chk("mrst_stall_cnt", 32'(stall_cnt), 0);
        chk("mrst_stall_cnt_w2", 32'(d2_stall_cnt), 0);
        in_valid = 0; rs1_used = 0; fv = 0; fp = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        m_full = 0; m_a = 0; m_b = 0; m_r2 = 0; m_cnt = 0; m_cnt2 = 0;
        repeat (600) rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised ID/EX operand stage for the riscv32i core, generalising the existing ALU source-A select to both ALU operands. Each cycle it selects operand A (register/PC/zero) and operand B (register/immediate/constant 4), resolves RAW hazards from NUM_FWD forwarding ports, and registers the result into a one-entry valid/ready pipeline slot feeding EX. It stalls on load-use hazards, honours a flush, and keeps a saturating stall counter.

## Interface
- XLEN, 32, datapath width
- NUM_FWD, 2, forwarding ports; index 0 is youngest (highest priority)
- RAW, 5, register address width
- STALL_CNT_W, 8, stall counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- in_valid  in  1  decoded instruction presented
- in_ready  out  1  stage accepts this cycle
- src_a_sel  in  2  0 FROM_REGFILE, 1 FROM_PC, 2 ZERO, 3 reserved (treated as ZERO)
- src_b_sel  in  2  0 FROM_REGFILE, 1 IMM, 2 CONST4, 3 reserved (treated as 0)
- rs1_used, rs2_used  in  1 each  instruction reads rs1 / rs2
- rs1_addr, rs2_addr  in  RAW each  source registers
- rs1_data, rs2_data  in  XLEN each  register-file read data
- pc, imm  in  XLEN each  instruction PC, sign-extended immediate
- fwd_valid  in  NUM_FWD  forwarding entry writes a register
- fwd_pending  in  NUM_FWD  entry's result not yet available (load in flight)
- fwd_addr  in  NUM_FWD*RAW  destination registers, packed, entry i at [i*RAW +: RAW]
- fwd_data  in  NUM_FWD*XLEN  results, packed likewise
- flush  in  1  kill slot contents and current input
- out_valid  out  1  operand slot full
- out_ready  in  1  EX consumes slot
- op_a, op_b  out  XLEN each  registered ALU operands
- rs2_val  out  XLEN  registered forwarded rs2 (store data/branch compare)
- stall_cnt  out  STALL_CNT_W  saturating count of hazard-stall cycles

## Operation
- Forward resolve per source s in {rs1, rs2}: match_i = fwd_valid[i] & fwd_addr_i==s_addr & s_addr!=0; lowest matching i wins; value = fwd_data_i if match, else s_data; address 0 always yields 0 regardless of s_data.
- Hazard: s_used & winning match has fwd_pending=1. Older pending entries shadowed by a younger non-pending match do not stall.
- Operand A: FROM_REGFILE -> resolved rs1; FROM_PC -> pc; ZERO/3 -> 0. Operand B: FROM_REGFILE -> resolved rs2; IMM -> imm; CONST4 -> 4; 3 -> 0.
- States: EMPTY (out_valid=0), FULL (out_valid=1). in_ready = !flush & !hazard & (EMPTY | out_ready).
- Accept (in_valid & in_ready): load op_a, op_b, rs2_val; next state FULL. FULL & out_ready & no accept: next EMPTY. Otherwise hold; outputs stable while FULL & !out_ready.
- flush: next state EMPTY, no accept that cycle; data registers may hold stale values.
- stall_cnt increments each cycle in_valid & hazard & !flush; saturates at 2^STALL_CNT_W-1; never clears except reset.

## Timing
- Reset (async assert, sync-safe release): out_valid=0, op_a=op_b=rs2_val=0, stall_cnt=0, state EMPTY; in_ready=1 combinationally once rst_n high and no hazard/flush.
- Latency: accepted on edge N, out_valid and operands visible after edge N; one-cycle stage, full throughput (accept and drain same cycle when out_ready=1).
- in_ready depends combinationally on flush, out_ready, hazard inputs; no combinational path from in_valid to in_ready.
- Hazard clears the cycle fwd_pending drops; instruction accepted that edge with forwarded fwd_data.
- flush beats simultaneous accept and drain. Reset mid-stall discards input, counter and slot.

## Test plan
- Reset then in_valid, src_a_sel=1, pc=0x100, src_b_sel=1, imm=0xFFFFFFF0 -> next cycle out_valid=1, op_a=0x100, op_b=0xFFFFFFF0.
- rs1_addr=5 REGFILE, fwd0 and fwd1 both addr 5 data 0xAA/0xBB, not pending -> op_a=0xAA; rs1_addr=0 with fwd addr 0 -> op_a=0.
- Load-use: rs2_used, rs2_addr=7, fwd1 pending addr 7 for 3 cycles -> in_ready=0 three cycles, stall_cnt=3, then accepted with rs2_val=fwd1 data.
- Backpressure: out_ready=0 for 4 cycles while FULL -> operands stable, in_ready=0; out_ready=1 with new in_valid -> back-to-back transfer, no bubble.
- flush while FULL with in_valid=1 -> next cycle out_valid=0, input not captured.
- STALL_CNT_W=2, 5 hazard cycles -> stall_cnt stops at 3; rst_n low mid-stall -> all outputs 0 immediately.
